// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit accumulator CPU.
// Opcode and controller state encodings plus the ALU helper.
package cpu_pkg;

    localparam int AW = 5;
    localparam int DW = 8;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        S_INST_ADDR  = 3'd0,
        S_INST_FETCH = 3'd1,
        S_INST_LOAD  = 3'd2,
        S_IDLE       = 3'd3,
        S_OP_ADDR    = 3'd4,
        S_OP_FETCH   = 3'd5,
        S_ALU_OP     = 3'd6,
        S_STORE      = 3'd7
    } state_t;

    // Non-ALU opcodes pass the accumulator through unchanged.
    function automatic logic [DW-1:0] alu(
        input opcode_t       op,
        input logic [DW-1:0] a,
        input logic [DW-1:0] b
    );
        logic [DW-1:0] r;
        r = a;
        case (op)
            OP_ADD:  r = a + b;
            OP_AND:  r = a & b;
            OP_XOR:  r = a ^ b;
            OP_LDA:  r = b;
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cpu_ctrl.sv
// Eight-state controller: sequences fetch/execute and
// decodes the datapath enables from state and opcode.
module cpu_ctrl
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       acc_zero,
    output logic       ir_ld,
    output logic       pc_inc,
    output logic       pc_ld,
    output logic       acc_ld,
    output logic       mem_wr,
    output logic       addr_sel,
    output logic       halt
);

    state_t  current_state;
    state_t  next_state;
    opcode_t op;
    logic    halt_q;

    assign op   = opcode_t'(opcode);
    assign halt = halt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            current_state <= S_INST_ADDR;
            halt_q        <= 1'b0;
        end else begin
            current_state <= next_state;
            if (current_state == S_OP_ADDR && op == OP_HLT) begin
                halt_q <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state = S_INST_ADDR;
        unique case (current_state)
            S_INST_ADDR:  next_state = S_INST_FETCH;
            S_INST_FETCH: next_state = S_INST_LOAD;
            S_INST_LOAD:  next_state = S_IDLE;
            S_IDLE:       next_state = S_OP_ADDR;
            S_OP_ADDR: begin
                if (op == OP_HLT) begin
                    next_state = S_OP_ADDR;
                end else begin
                    next_state = S_OP_FETCH;
                end
            end
            S_OP_FETCH:   next_state = S_ALU_OP;
            S_ALU_OP:     next_state = S_STORE;
            S_STORE:      next_state = S_INST_ADDR;
        endcase
    end

    // HLT still bumps PC once on its first OP_ADDR cycle, then freezes.
    always_comb begin
        ir_ld    = 1'b0;
        pc_inc   = 1'b0;
        pc_ld    = 1'b0;
        acc_ld   = 1'b0;
        mem_wr   = 1'b0;
        addr_sel = 1'b0;
        unique case (current_state)
            S_INST_ADDR:  ;
            S_INST_FETCH: ;
            S_INST_LOAD:  ir_ld = 1'b1;
            S_IDLE:       ;
            S_OP_ADDR: begin
                addr_sel = 1'b1;
                pc_inc   = ~halt_q;
            end
            S_OP_FETCH: begin
                addr_sel = 1'b1;
            end
            S_ALU_OP: begin
                addr_sel = 1'b1;
                unique case (1'b1)
                    op == OP_ADD,
                    op == OP_AND,
                    op == OP_XOR,
                    op == OP_LDA: acc_ld = 1'b1;
                    op == OP_SKZ: pc_inc = acc_zero;
                    op == OP_JMP: pc_ld  = 1'b1;
                    default:      ;
                endcase
            end
            S_STORE: begin
                addr_sel = 1'b1;
                mem_wr   = (op == OP_STO);
            end
        endcase
    end

endmodule

// File: rtl/cpu_mem.sv
// Unified 32x8 instruction/data memory.
// Combinational read, synchronous write, never cleared by reset.
module cpu_mem
    import cpu_pkg::*;
#(
    parameter int AW = cpu_pkg::AW,
    parameter int DW = cpu_pkg::DW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/cpu_top.sv
// 8-bit accumulator CPU top: PC, IR, ACC and ALU datapath
// around the controller and unified memory.
module cpu_top
    import cpu_pkg::*;
#(
    parameter int AW = cpu_pkg::AW,
    parameter int DW = cpu_pkg::DW
) (
    input  logic clk,
    input  logic rst,
    output logic halt
);

    logic [AW-1:0] pc_out;
    logic [DW-1:0] ir_out;
    logic [DW-1:0] acc_out;

    logic [AW-1:0] addr;
    logic [DW-1:0] rdata;
    logic [2:0]    opcode;

    logic ir_ld;
    logic pc_inc;
    logic pc_ld;
    logic acc_ld;
    logic mem_wr;
    logic addr_sel;
    logic acc_zero;

    assign opcode   = ir_out[DW-1 -: 3];
    assign acc_zero = (acc_out == '0);
    assign addr     = addr_sel ? ir_out[AW-1:0] : pc_out;

    cpu_ctrl ctrl (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .acc_zero (acc_zero),
        .ir_ld    (ir_ld),
        .pc_inc   (pc_inc),
        .pc_ld    (pc_ld),
        .acc_ld   (acc_ld),
        .mem_wr   (mem_wr),
        .addr_sel (addr_sel),
        .halt     (halt)
    );

    cpu_mem #(
        .AW (AW),
        .DW (DW)
    ) mem (
        .clk   (clk),
        .we    (mem_wr),
        .addr  (addr),
        .wdata (acc_out),
        .rdata (rdata)
    );

    // PC wraps naturally at the top of the address space.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out <= '0;
        end else if (pc_ld) begin
            pc_out <= ir_out[AW-1:0];
        end else if (pc_inc) begin
            pc_out <= pc_out + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_out <= '0;
        end else if (ir_ld) begin
            ir_out <= rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_out <= '0;
        end else if (acc_ld) begin
            acc_out <= alu(opcode_t'(opcode), acc_out, rdata);
        end
    end

endmodule

// File: tb/tb_cpu_top.sv
// Self-checking bench for cpu_top: store scoreboard plus
// final-state checks for each program scenario.
module tb_cpu_top;

    localparam logic [2:0] HLT = 3'd0;
    localparam logic [2:0] SKZ = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] AND = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] LDA = 3'd5;
    localparam logic [2:0] STO = 3'd6;
    localparam logic [2:0] JMP = 3'd7;

    logic clk;
    logic rst;
    logic halt;

    int n_cmp;
    int n_err;

    logic [7:0]  img [32];
    logic [12:0] exp_q [$];
    logic [12:0] obs_q [$];

    cpu_top dut (
        .clk  (clk),
        .rst  (rst),
        .halt (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every memory write the DUT performs, as {addr, data}.
    always @(negedge clk) begin
        if (dut.ctrl.mem_wr === 1'b1) begin
            obs_q.push_back({dut.ir_out[4:0], dut.acc_out});
        end
    end

    function automatic logic [7:0] ins(
        input logic [2:0] op,
        input logic [4:0] a
    );
        return {op, a};
    endfunction

    task automatic clear_img();
        for (int i = 0; i < 32; i++) img[i] = 8'h00;
    endtask

    task automatic boot();
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 32; i++) dut.mem.mem[i] = img[i];
        obs_q.delete();
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run(
        input  int budget,
        output bit wrapped
    );
        int          cyc;
        logic [4:0]  prev;
        cyc     = 0;
        wrapped = 1'b0;
        prev    = dut.pc_out;
        while (halt !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (prev == 5'd31 && dut.pc_out == 5'd0) wrapped = 1'b1;
            prev = dut.pc_out;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({dut.pc_out, dut.ir_out, dut.acc_out} !== 21'd0) begin
            n_err++;
            $display("FAIL reset_regs: pc/ir/acc=%h/%h/%h want 0",
                     dut.pc_out, dut.ir_out, dut.acc_out);
        end
        n_cmp++;
        if (dut.ctrl.current_state !== 3'd0 || halt !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: state=%0d halt=%b want 0/0",
                     dut.ctrl.current_state, halt);
        end
    endtask

    task automatic test_main();
        bit w;
        clear_img();
        img[0]  = ins(LDA, 10); img[1]  = ins(ADD, 11);
        img[2]  = ins(STO, 12); img[3]  = ins(LDA, 13);
        img[4]  = ins(AND, 14); img[5]  = ins(STO, 15);
        img[6]  = ins(JMP, 20); img[7]  = ins(HLT, 0);
        img[20] = ins(LDA, 16); img[21] = ins(XOR, 17);
        img[22] = ins(STO, 18); img[23] = ins(HLT, 0);
        img[10] = 8'h05; img[11] = 8'h0A; img[13] = 8'hF0;
        img[14] = 8'h0F; img[16] = 8'hAA; img[17] = 8'h55;
        img[12] = 8'h77; img[15] = 8'h77; img[18] = 8'h77;
        boot();
        exp_q.push_back({5'd12, 8'h0F});
        exp_q.push_back({5'd15, 8'h00});
        exp_q.push_back({5'd18, 8'hFF});
        run(500, w);
        n_cmp++;
        if (halt !== 1'b1) begin
            n_err++;
            $display("FAIL main_halt: halt=%b want 1 in 500 clk", halt);
        end
        n_cmp++;
        if (dut.pc_out !== 5'd24) begin
            n_err++;
            $display("FAIL main_pc: pc=%0d want 24", dut.pc_out);
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL main_nstore: got %0d want %0d",
                     obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [12:0] e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL main_store: got M%0d=%h want M%0d=%h",
                         o[12:8], o[7:0], e[12:8], e[7:0]);
            end
        end
        n_cmp++;
        if (dut.mem.mem[12] !== 8'h0F || dut.mem.mem[15] !== 8'h00 ||
            dut.mem.mem[18] !== 8'hFF) begin
            n_err++;
            $display("FAIL main_mem: M12/15/18=%h/%h/%h want 0F/00/FF",
                     dut.mem.mem[12], dut.mem.mem[15], dut.mem.mem[18]);
        end
    endtask

    task automatic test_skz();
        bit w;
        logic [7:0] v;
        for (int k = 0; k < 2; k++) begin
            v = (k == 0) ? 8'h00 : 8'h07;
            clear_img();
            img[0] = ins(LDA, 10); img[1] = ins(SKZ, 0);
            img[2] = ins(STO, 11); img[3] = ins(STO, 12);
            img[4] = ins(HLT, 0);
            img[10] = v; img[11] = 8'h5A; img[12] = 8'h33;
            boot();
            if (k == 1) exp_q.push_back({5'd11, v});
            exp_q.push_back({5'd12, v});
            run(300, w);
            n_cmp++;
            if (halt !== 1'b1 || dut.pc_out !== 5'd5) begin
                n_err++;
                $display("FAIL skz%0d_halt: halt=%b pc=%0d want 1/5",
                         k, halt, dut.pc_out);
            end
            n_cmp++;
            if (obs_q.size() != exp_q.size()) begin
                n_err++;
                $display("FAIL skz%0d_nstore: got %0d want %0d",
                         k, obs_q.size(), exp_q.size());
            end
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                logic [12:0] e, o;
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                n_cmp++;
                if (o !== e) begin
                    n_err++;
                    $display("FAIL skz%0d_store: got M%0d=%h want M%0d=%h",
                             k, o[12:8], o[7:0], e[12:8], e[7:0]);
                end
            end
            n_cmp++;
            if (dut.mem.mem[11] !== ((k == 0) ? 8'h5A : v)) begin
                n_err++;
                $display("FAIL skz%0d_x: M11=%h want %h",
                         k, dut.mem.mem[11], (k == 0) ? 8'h5A : v);
            end
        end
    endtask

    task automatic test_hlt_at_zero();
        clear_img();
        boot();
        repeat (4) @(negedge clk);
        n_cmp++;
        if (halt !== 1'b0) begin
            n_err++;
            $display("FAIL hlt0_early: halt=%b want 0 at clk 4", halt);
        end
        @(negedge clk);
        n_cmp++;
        if (halt !== 1'b1) begin
            n_err++;
            $display("FAIL hlt0_rise: halt=%b want 1 at clk 5", halt);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if (halt !== 1'b1 || dut.pc_out !== 5'd1 ||
                dut.ctrl.current_state !== 3'd4) begin
                n_err++;
                $display("FAIL hlt0_hold: clk%0d halt=%b pc=%0d st=%0d want 1/1/4",
                         i, halt, dut.pc_out, dut.ctrl.current_state);
            end
        end
    endtask

    task automatic test_pc_wrap();
        bit w;
        clear_img();
        img[0]  = ins(JMP, 30);
        img[30] = ins(LDA, 1);
        img[31] = ins(STO, 0);
        boot();
        exp_q.push_back({5'd0, 8'h00});
        run(300, w);
        n_cmp++;
        if (w !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_seen: wrapped=%b want 1", w);
        end
        n_cmp++;
        if (halt !== 1'b1 || dut.pc_out !== 5'd1) begin
            n_err++;
            $display("FAIL wrap_halt: halt=%b pc=%0d want 1/1",
                     halt, dut.pc_out);
        end
        n_cmp++;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            n_err++;
            $display("FAIL wrap_store: n=%0d first=%h want 1/%h",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 13'h0,
                     exp_q[0]);
        end
    endtask

    task automatic test_reset_mid();
        bit w;
        bit found;
        clear_img();
        img[0] = ins(LDA, 10); img[1] = ins(ADD, 11);
        img[2] = ins(STO, 12); img[3] = ins(HLT, 0);
        img[10] = 8'h03; img[11] = 8'h04; img[12] = 8'hEE;
        boot();
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (dut.ctrl.current_state == 3'd5 && dut.ir_out[7:5] == ADD)
                found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL rstmid_reach: ADD state 5 seen=%b want 1", found);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (dut.pc_out !== 5'd0 || dut.acc_out !== 8'h00 ||
            dut.ctrl.current_state !== 3'd0 || halt !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_regs: pc=%0d acc=%h st=%0d halt=%b want 0",
                     dut.pc_out, dut.acc_out, dut.ctrl.current_state, halt);
        end
        n_cmp++;
        if (dut.mem.mem[10] !== 8'h03 || dut.mem.mem[11] !== 8'h04 ||
            dut.mem.mem[12] !== 8'hEE) begin
            n_err++;
            $display("FAIL rstmid_mem: M10/11/12=%h/%h/%h want 03/04/EE",
                     dut.mem.mem[10], dut.mem.mem[11], dut.mem.mem[12]);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.push_back({5'd12, 8'h07});
        run(300, w);
        n_cmp++;
        if (halt !== 1'b1 || dut.pc_out !== 5'd4) begin
            n_err++;
            $display("FAIL rstmid_rerun: halt=%b pc=%0d want 1/4",
                     halt, dut.pc_out);
        end
        n_cmp++;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            n_err++;
            $display("FAIL rstmid_store: n=%0d first=%h want 1/%h",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 13'h0,
                     exp_q[0]);
        end
    endtask

    task automatic test_overflow();
        bit w;
        clear_img();
        img[0] = ins(LDA, 10); img[1] = ins(ADD, 11);
        img[2] = ins(STO, 12); img[3] = ins(HLT, 0);
        img[10] = 8'hFF; img[11] = 8'h02; img[12] = 8'h5A;
        boot();
        exp_q.push_back({5'd12, 8'h01});
        run(300, w);
        n_cmp++;
        if (halt !== 1'b1 || dut.pc_out !== 5'd4 ||
            dut.acc_out !== 8'h01) begin
            n_err++;
            $display("FAIL ovf_state: halt=%b pc=%0d acc=%h want 1/4/01",
                     halt, dut.pc_out, dut.acc_out);
        end
        n_cmp++;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            n_err++;
            $display("FAIL ovf_store: n=%0d first=%h want 1/%h",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 13'h0,
                     exp_q[0]);
        end
        n_cmp++;
        if (dut.mem.mem[10] !== 8'hFF || dut.mem.mem[11] !== 8'h02) begin
            n_err++;
            $display("FAIL ovf_side: M10/11=%h/%h want FF/02",
                     dut.mem.mem[10], dut.mem.mem[11]);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        test_reset();
        test_main();
        test_skz();
        test_hlt_at_zero();
        test_pc_wrap();
        test_reset_mid();
        test_overflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
